// File: rtl/pattern_generator_if.sv
// Round-level signal bundle between the memory-game controller and its pattern generator.
// The master side drives the player/button inputs; the slave side is the generator.
interface pattern_generator_if;
   logic        start;
   logic [3:0]  level;
   logic [3:0]  guess;
   logic        guessValid;
   logic        timeout;
   logic [15:0] ledOut;
   logic        showing;
   logic        awaitInput;
   logic [3:0]  stepIdx;
   logic        busy;
   logic        roundPass;
   logic        roundFail;

   modport master (
      output start, level, guess, guessValid, timeout,
      input  ledOut, showing, awaitInput, stepIdx, busy, roundPass, roundFail
   );

   modport slave (
      input  start, level, guess, guessValid, timeout,
      output ledOut, showing, awaitInput, stepIdx, busy, roundPass, roundFail
   );
endinterface

// File: rtl/pattern_generator.sv
// Memory-game pattern generator: shows an LFSR-derived LED sequence, then checks the
// player's guesses against it and reports a single pass or fail pulse per round.
module pattern_generator #(
   parameter int unsigned SEQ_LEN     = 8,
   parameter int unsigned SHOW_CYCLES = 50_000_000,
   parameter int unsigned GAP_CYCLES  = 12_500_000,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input logic               clk,
   input logic               rst,
   pattern_generator_if.slave bus
);

   localparam int unsigned MAX_DWELL = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
   localparam int unsigned IDX_W     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [4:0]  SEQ_LEN_W = 5'(SEQ_LEN);
   localparam logic [3:0]  MAX_IDX   = 4'(SEQ_LEN - 1);
   localparam logic [15:0] SEED_NZ   = (SEED == '0) ? 16'h0001 : SEED;

   typedef enum logic [2:0] {sIdle, sLoad, sShow, sGap, sInput, sPass, sFail} stateT;

   stateT            state, stateNext;
   logic [15:0]      freeLfsr, playLfsr;
   logic [CNT_W-1:0] dwell;
   logic [3:0]       idx, lastIdx, levelIdx;
   logic [3:0]       mem [SEQ_LEN];
   logic             dwellDone, isLast, guessOk;

   logic [15:0] ledNext;
   logic        showingNext, awaitNext, busyNext, passNext, failNext;

   function automatic logic [15:0] lfsrNext(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   assign dwellDone = (state == sShow) ? (dwell == SHOW_LAST) : (dwell == GAP_LAST);
   assign isLast    = (idx == lastIdx);
   assign guessOk   = (bus.guess == mem[idx[IDX_W-1:0]]);

   // N is held as its last index (N-1) so step comparisons stay 4 bits wide.
   always_comb begin
      if (bus.level == '0)
         levelIdx = '0;
      else if ({1'b0, bus.level} > SEQ_LEN_W)
         levelIdx = MAX_IDX;
      else
         levelIdx = bus.level - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= sIdle;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         sIdle:  if (bus.start) stateNext = sLoad;
         sLoad:  stateNext = sShow;
         sShow:  if (dwellDone) stateNext = isLast ? sInput : sGap;
         sGap:   if (dwellDone) stateNext = sShow;
         sInput: begin
            if (bus.timeout)
               stateNext = sFail;
            else if (bus.guessValid) begin
               if (!guessOk)    stateNext = sFail;
               else if (isLast) stateNext = sPass;
            end
         end
         sPass, sFail: stateNext = sIdle;
         default:      stateNext = sIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         freeLfsr <= SEED_NZ;
         playLfsr <= '0;
         dwell    <= '0;
         idx      <= '0;
         lastIdx  <= '0;
      end else begin
         freeLfsr <= lfsrNext(freeLfsr);
         if (stateNext != state) dwell <= '0;
         else                    dwell <= dwell + CNT_W'(1);
         case (state)
            sIdle: if (bus.start) begin
               idx     <= '0;
               lastIdx <= levelIdx;
            end
            sLoad: begin
               idx      <= '0;
               playLfsr <= freeLfsr;
            end
            sShow: if (dwellDone) begin
               playLfsr <= lfsrNext(playLfsr);
               if (isLast) idx <= '0;
            end
            sGap: if (dwellDone) idx <= idx + 4'd1;
            sInput: if (!bus.timeout && bus.guessValid && guessOk && !isLast) idx <= idx + 4'd1;
            sPass, sFail: idx <= '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == sShow) mem[idx[IDX_W-1:0]] <= playLfsr[3:0];
   end

   // Outputs are registered from the current state, so they trail it by one cycle.
   always_comb begin
      ledNext     = (state == sShow) ? (16'd1 << playLfsr[3:0]) : '0;
      showingNext = (state inside {sShow, sGap});
      awaitNext   = (state == sInput);
      busyNext    = (state != sIdle);
      passNext    = (state == sPass);
      failNext    = (state == sFail);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.ledOut     <= '0;
         bus.showing    <= 1'b0;
         bus.awaitInput <= 1'b0;
         bus.stepIdx    <= '0;
         bus.busy       <= 1'b0;
         bus.roundPass  <= 1'b0;
         bus.roundFail  <= 1'b0;
      end else begin
         bus.ledOut     <= ledNext;
         bus.showing    <= showingNext;
         bus.awaitInput <= awaitNext;
         bus.stepIdx    <= idx;
         bus.busy       <= busyNext;
         bus.roundPass  <= passNext;
         bus.roundFail  <= failNext;
      end
   end

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator: a round-timeline reference model checked every cycle,
// directed round scenarios with literal expectations, then randomized play.
module tb_pattern_generator;
   localparam int SHOW = 4;
   localparam int GAP  = 2;
   localparam int SEQ  = 8;
   localparam logic [15:0] SEEDV = 16'hACE1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   pattern_generator_if bus();

   pattern_generator #(
      .SEQ_LEN(SEQ), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .SEED(SEEDV)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: a round is described by its accept edge, its length and its decision edge.
   longint      edgeNum = 0;
   bit          mActive = 1'b0;
   bit          mDecided;
   bit          mPass;
   longint      mK, mD;
   int          mN, mL, mCorrect = 0;
   logic [3:0]  mSeq [16];
   logic [15:0] mFree;

   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge clk) begin : model
      logic [15:0] xLed;
      logic        xShow, xAwait, xBusy, xPass, xFail;
      logic [3:0]  xIdx;
      logic [15:0] v;
      longint      p, o;
      int          lvl, step;
      bit          idleBefore;
      edgeNum++;
      xLed = '0; xShow = 0; xAwait = 0; xBusy = 0; xPass = 0; xFail = 0; xIdx = '0;
      idleBefore = !mActive || (mDecided && (edgeNum - 1 > mD));
      if (rst && !idleBefore) begin
         p = edgeNum - 1 - mK;
         if (mDecided && (edgeNum - 1 == mD)) begin
            xBusy = 1; xPass = mPass; xFail = !mPass; xIdx = 4'(mCorrect);
         end else if (p == 0) begin
            xBusy = 1;
         end else if (p <= mL) begin
            o = p - 1;
            step = int'(o / (SHOW + GAP));
            xShow = 1; xBusy = 1; xIdx = 4'(step);
            if ((o % (SHOW + GAP)) < SHOW) xLed = 16'd1 << mSeq[step];
         end else begin
            xAwait = 1; xBusy = 1; xIdx = 4'(mCorrect);
         end
      end

      if (!rst) begin
         mActive = 0;
         mFree   = SEEDV;
      end else begin
         mFree = lfsrStep(mFree);
         if (idleBefore) begin
            if (bus.start) begin
               lvl = int'(bus.level);
               mN = (lvl == 0) ? 1 : ((lvl > SEQ) ? SEQ : lvl);
               mL = mN * SHOW + (mN - 1) * GAP;
               mActive = 1; mDecided = 0; mK = edgeNum; mCorrect = 0;
               v = mFree;
               for (int i = 0; i < mN; i++) begin
                  mSeq[i] = v[3:0];
                  v = lfsrStep(v);
               end
            end
         end else if (!mDecided && (edgeNum - 1 - mK > mL)) begin
            if (bus.timeout) begin
               mDecided = 1; mD = edgeNum; mPass = 0;
            end else if (bus.guessValid) begin
               if (bus.guess != mSeq[mCorrect]) begin
                  mDecided = 1; mD = edgeNum; mPass = 0;
               end else if (mCorrect == mN - 1) begin
                  mDecided = 1; mD = edgeNum; mPass = 1;
               end else begin
                  mCorrect++;
               end
            end
         end
      end

      #1;
      tests++;
      if (bus.ledOut !== xLed || bus.showing !== xShow || bus.awaitInput !== xAwait ||
          bus.busy !== xBusy || bus.roundPass !== xPass || bus.roundFail !== xFail ||
          bus.stepIdx !== xIdx) begin
         fails++;
         $display("FAIL outputs @edge %0d: got led=%h show=%b await=%b busy=%b pass=%b fail=%b idx=%0d, required led=%h show=%b await=%b busy=%b pass=%b fail=%b idx=%0d",
                  edgeNum, bus.ledOut, bus.showing, bus.awaitInput, bus.busy, bus.roundPass,
                  bus.roundFail, bus.stepIdx, xLed, xShow, xAwait, xBusy, xPass, xFail, xIdx);
      end
   end

   task automatic pin(input string nm, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic startRound(input logic [3:0] lvl);
      @(negedge clk);
      bus.level = lvl;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic guessOnce(input logic [3:0] g, input logic to);
      @(negedge clk);
      bus.guess = g; bus.guessValid = 1'b1; bus.timeout = to;
      @(negedge clk);
      bus.guessValid = 1'b0; bus.timeout = 1'b0;
   endtask

   task automatic waitAwait(input string nm, output int waited);
      waited = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.awaitInput) begin
            waited = i;
            break;
         end
      end
      if (waited == 0) begin
         tests++; fails++;
         $display("FAIL %s: awaitInput still 0 after 200 cycles, required 1", nm);
      end
   endtask

   task automatic waitIdle(input string nm);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) return;
      end
      tests++; fails++;
      $display("FAIL %s: busy still 1 after 200 cycles, required 0", nm);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: bench still running at 1 ms, required completion");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int w;
      bus.start = 0; bus.level = '0; bus.guess = '0; bus.guessValid = 0; bus.timeout = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      pin("reset busy", 16'(bus.busy), 16'h0);
      pin("reset ledOut", bus.ledOut, 16'h0);

      // First round from the seed: LOAD sees LFSR 59C3, steps 3, 7, F.
      rst = 1'b1; bus.level = 4'd3; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(posedge clk); #1 pin("load busy", 16'(bus.busy), 16'h1);
      @(posedge clk); #1 pin("step0 led", bus.ledOut, 16'h0008);
      repeat (6) @(posedge clk); #1 pin("step1 led", bus.ledOut, 16'h0080);
      repeat (6) @(posedge clk); #1 pin("step2 led", bus.ledOut, 16'h8000);
      repeat (3) @(posedge clk); #1 pin("await early", 16'(bus.awaitInput), 16'h0);
      @(posedge clk); #1 pin("await at 16", 16'(bus.awaitInput), 16'h1);
      guessOnce(4'h3, 0); guessOnce(4'h7, 0); guessOnce(4'hF, 0);
      @(posedge clk); #1 pin("pass pulse", 16'(bus.roundPass), 16'h1);
      pin("pass no fail", 16'(bus.roundFail), 16'h0);
      @(posedge clk); #1 pin("pass pulse end", 16'(bus.roundPass), 16'h0);
      pin("idle after pass", 16'(bus.busy), 16'h0);

      // Wrong second guess, third guess must be ignored.
      startRound(4'd3); waitAwait("fail round", w); pin("fail round wait", 16'(w), 16'd18);
      guessOnce(mSeq[0], 0); guessOnce(mSeq[1] ^ 4'h1, 0);
      @(posedge clk); #1 pin("fail pulse", 16'(bus.roundFail), 16'h1);
      pin("fail no pass", 16'(bus.roundPass), 16'h0);
      guessOnce(mSeq[2], 0);
      waitIdle("fail round");

      // level 0 clamps to one step; timeout beats a correct guess.
      startRound(4'd0); waitAwait("level0", w); pin("level0 wait", 16'(w), 16'd6);
      guessOnce(mSeq[0], 1);
      @(posedge clk); #1 pin("timeout priority", 16'(bus.roundFail), 16'h1);
      waitIdle("level0");

      // level 15 clamps to SEQ_LEN steps.
      startRound(4'd15); waitAwait("level15", w); pin("level15 wait", 16'(w), 16'd48);
      for (int i = 0; i < SEQ; i++) guessOnce(mSeq[i], 0);
      @(posedge clk); #1 pin("level15 pass", 16'(bus.roundPass), 16'h1);
      waitIdle("level15");

      // start during SHOW and guessValid during GAP are both ignored.
      startRound(4'd4);
      @(negedge clk); @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); @(negedge clk); bus.guess = mSeq[0]; bus.guessValid = 1'b1;
      @(negedge clk); bus.guessValid = 1'b0;
      waitAwait("ignored inputs", w); pin("ignored inputs wait", 16'(w), 16'd18);
      for (int i = 0; i < 4; i++) guessOnce(mSeq[i], 0);
      @(posedge clk); #1 pin("ignored inputs pass", 16'(bus.roundPass), 16'h1);
      waitIdle("ignored inputs");

      // Reset mid-SHOW aborts silently; a fresh round follows.
      startRound(4'd5);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      pin("midreset busy", 16'(bus.busy), 16'h0);
      pin("midreset ledOut", bus.ledOut, 16'h0);
      pin("midreset stepIdx", 16'(bus.stepIdx), 16'h0);
      rst = 1'b1;
      startRound(4'd2); waitAwait("after reset", w); pin("after reset wait", 16'(w), 16'd12);
      guessOnce(mSeq[0], 0); guessOnce(mSeq[1], 0);
      @(posedge clk); #1 pin("after reset pass", 16'(bus.roundPass), 16'h1);
      waitIdle("after reset");

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst            = ($urandom_range(0, 599) != 0);
         bus.level      = 4'($urandom_range(0, 15));
         bus.start      = ($urandom_range(0, 9) == 0);
         bus.timeout    = ($urandom_range(0, 59) == 0);
         bus.guessValid = bus.awaitInput ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         bus.guess      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : mSeq[mCorrect];
      end

      @(negedge clk);
      rst = 1'b1; bus.start = 1'b0; bus.guessValid = 1'b0; bus.timeout = 1'b1;
      waitIdle("drain");
      bus.timeout = 1'b0;
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pattern_generator.md
# pattern_generator

Generates the pseudo-random LED pattern for one round of the memory game, plays it on the red LEDs, then checks the player's switch entries against it. It sits upstream of the access controller and score tracker:
- `ledOut` drives `redLight`.
- `roundPass` and `roundFail` feed score update.
- `timeout` comes from the digit-timer chain.

One round: `start`, then show N steps, then collect N guesses, then a single pass or fail pulse.

## Interface
- `SEQ_LEN`, default 8: maximum steps per round, 1..16.
- `SHOW_CYCLES`, default 50_000_000: clocks each step is lit.
- `GAP_CYCLES`, default 12_500_000: dark clocks between steps.
- `SEED`, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse (button shaper output). Begins a round.
- `level`  in  4  requested step count. Sampled at start.
- `guess`  in  4  player's switch value.
- `guessValid`  in  1  one-cycle pulse; qualifies `guess`.
- `timeout`  in  1  pulse from round timer. Aborts input.
- `ledOut`  out  16  one-hot LED of the shown step; 0 otherwise.
- `showing`  out  1  high in SHOW and GAP.
- `awaitInput`  out  1  high in INPUT.
- `stepIdx`  out  4  current step index (shown or expected).
- `busy`  out  1  high in every state except IDLE.
- `roundPass`  out  1  one-cycle pulse on successful round.
- `roundFail`  out  1  one-cycle pulse on wrong guess or timeout.

## Operation
- **Free-running LFSR**
  - 16-bit Fibonacci LFSR, taps 16, 14, 13, 11.
  - Advances every clock, including during rounds.
  - Never reaches 0.
- **Step count:** N = `level`, clamped. `level` = 0 gives N = 1; `level` > `SEQ_LEN` gives N = `SEQ_LEN`.
- **Play LFSR:** loaded from the free LFSR in LOAD. It advances once at the end of each SHOW step only.
- **Step value:** step value = play LFSR[3:0]. It is stored in `mem[stepIdx]` (`SEQ_LEN` × 4-bit register array) during SHOW.
- **State machine:**
  - IDLE
    - `start` → LOAD.
    - All other inputs are ignored.
  - LOAD (1 cycle)
    - Latch N; load play LFSR.
    - Set `stepIdx` = 0.
    - Go to SHOW.
  - SHOW (`SHOW_CYCLES` cycles)
    - `ledOut` = 1 << value; store the value.
    - When the dwell expires, advance the play LFSR:
      - if `stepIdx` = N−1, set `stepIdx` = 0 and go to INPUT;
      - else go to GAP.
  - GAP (`GAP_CYCLES` cycles)
    - `ledOut` = 0.
    - Then increment `stepIdx` and go to SHOW.
  - INPUT: `ledOut` = 0. On `guessValid`:
    - `guess` ≠ `mem[stepIdx]` → FAIL;
    - else if `stepIdx` = N−1 → PASS;
    - else increment `stepIdx`.
  - PASS / FAIL (1 cycle each)
    - Pulse `roundPass` / `roundFail`.
    - Go to IDLE.
- **`timeout`**
  - In INPUT → FAIL. This has priority over a same-cycle `guessValid`.
  - Ignored in every other state.
- **Ignored inputs:**
  - `start` while busy is ignored; it does not restart the round.
  - `guessValid` outside INPUT is ignored.
- **Dwell counter:** single counter, sized for max(`SHOW_CYCLES`, `GAP_CYCLES`). Cleared on every state entry.

## Timing
- **Reset:** with `rst` low at a clock edge:
  - state = IDLE;
  - all outputs 0, `stepIdx` = 0;
  - free LFSR = `SEED`; counters 0.
  - `mem` contents need not be cleared.
  - Reset mid-round aborts the round with no pass/fail pulse.
- All outputs are registered.
- **Round start:** `start` sampled at edge k:
  - `busy` = 1 from k+1 (LOAD);
  - first `ledOut` nonzero from k+2;
  - LED held exactly `SHOW_CYCLES` cycles.
- **Show phase length:** N·`SHOW_CYCLES` + (N−1)·`GAP_CYCLES` cycles. `awaitInput` rises the cycle after the last SHOW cycle.
- **Guess response:** guess at edge g:
  - a mismatch or the final match shows its pulse at g+1;
  - `busy` falls at g+2.
- **Back-to-back rounds:** `start` is accepted again from the first IDLE cycle after a pulse.

## Test plan
Directed scenarios use `SHOW_CYCLES`=4, `GAP_CYCLES`=2, `SEQ_LEN`=8, `SEED`=16'hACE1.

1. **Reset:** hold `rst`=0 for 3 clocks mid-SHOW.
   - All outputs 0, `busy`=0.
   - After release, `start` launches a fresh round.
2. **Show timing:** `level`=3, `start` pulse.
   - Pattern: 4 lit, 2 dark, 4 lit, 2 dark, 4 lit; each lit `ledOut` is one-hot and matches the reference-model LFSR[3:0].
   - `awaitInput`=1 after 16 cycles.
3. **Pass:** `level`=3; feed the 3 correct values.
   - `roundPass`=1 for exactly 1 cycle.
   - `roundFail` stays 0; IDLE follows.
4. **Fail:** `level`=3; first guess correct, second wrong.
   - `roundFail` pulses 1 cycle after the second guess.
   - The third guess is ignored.
5. **Clamping:**
   - `level`=0 → 1 step shown.
   - `level`=15 → 8 steps shown (8×4 + 7×2 = 46 cycles).
6. **Priority and ignored inputs:**
   - `timeout` and `guessValid` (correct guess) in the same INPUT cycle → `roundFail`.
   - `start` pulsed during SHOW → no restart, sequence unchanged.
   - `guessValid` during GAP → ignored.
